neorv32_wb_mailbox: RTL and testbench
=====================================

# neorv32_wb_mailbox

Wishbone classic responder that terminates the NEORV32 external bus initiator inside the user project. It provides a byte-writable scratch register, a control register, and a status register. It also provides a transmit mailbox FIFO whose drain side is a valid/ready stream for a downstream consumer such as a pad-side serializer or LA capture. An optional level interrupt flags an empty mailbox.

## Interface
- BASE_ADDR, 32'h9000_0000: block base address; decode compares wb_adr_i[31:4] with BASE_ADDR[31:4].
- FIFO_DEPTH, 8: mailbox depth in 32-bit words; power of two, 2..32.
- LVL_W, $clog2(FIFO_DEPTH)+1: width of the fill-level field.

Ports:
- clk_i  in  1  system clock; all logic on the rising edge.
- rstn_i  in  1  asynchronous, active-low reset.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  1 = write.
- wb_sel_i  in  4  byte enables.
- wb_adr_i  in  32  byte address.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, valid only while wb_ack_o = 1, else 0.
- wb_ack_o  out  1  single-cycle acknowledge.
- wb_err_o  out  1  single-cycle error termination.
- fifo_dout_o  out  32  head word (show-ahead).
- fifo_valid_o  out  1  FIFO non-empty.
- fifo_ready_i  in  1  consumer pops the head when valid & ready at a clock edge.
- irq_o  out  1  CTRL.irq_en & FIFO empty, registered.

## Operation
- Register map (offset from BASE_ADDR, selected by adr[3:2]):
  - 0x0 SCRATCH: RW. Write honours wb_sel_i per byte.
  - 0x4 TXDATA: WO, reads 0. A write pushes wb_dat_i. A TXDATA write requires wb_sel_i = 4'hF; otherwise wb_err_o is asserted and nothing is pushed.
  - 0x8 STATUS: RO, except bit2 which is write-1-to-clear.
    - bit0 empty.
    - bit1 full.
    - bit2 overflow (sticky).
    - bits[8+LVL_W-1:8] fill level.
    - Other bits 0.
  - 0xC CTRL: RW.
    - bit0 irq_en.
    - bit1 flush: self-clearing; writing 1 empties the FIFO; reads 0.
    - Other bits read 0.
- Requests outside the BASE_ADDR window get neither ack nor err; the interconnect or another responder owns them.
- Push to a full FIFO: the write is still acked, the data is dropped, and overflow is set. A push and a pop in the same edge with the FIFO full both succeed; level is unchanged.
- Pop with the FIFO empty is ignored; fifo_valid_o = 0.
- Flush and a pop in the same cycle: flush wins, level = 0.
- Flush and a STATUS overflow-clear are independent.
- Level arithmetic: an LVL_W-bit counter; read and write pointers wrap modulo FIFO_DEPTH. full = (level == FIFO_DEPTH).
- Responder FSM states:
  - IDLE → RESP on cyc & stb & in-range.
  - RESP asserts exactly one of ack or err for one cycle, then → IDLE unconditionally.
  - While in RESP, stb is ignored, so no request is double-counted.
- Reset (asynchronous, any time, including mid-transfer):
  - wb_ack_o = wb_err_o = 0 and wb_dat_o = 0 immediately.
  - FSM goes to IDLE.
  - SCRATCH = 0, CTRL = 0, overflow = 0.
  - FIFO pointers and level = 0, so fifo_valid_o = 0; fifo_dout_o is don't-care but driven 0.
  - irq_o = 0.

## Timing
- Request sampled at edge N (IDLE, cyc & stb & in-range). wb_ack_o or wb_err_o is high from after edge N until edge N+1. Read data is registered at edge N.
- Write side effects (register update, push, W1C, flush) take effect at edge N. STATUS read at edge N+1 reflects them.
- Maximum throughput is one transfer per 2 cycles. The initiator drops stb or keeps it for a new request; a held stb is re-sampled at edge N+1.
- fifo_valid_o rises the cycle after the pushing edge. A pop at edge M makes the next word visible after edge M.
- irq_o is registered and updates one edge after empty or irq_en changes.
- Abandoned cycle (cyc dropped while in RESP): ack still pulses once; the write effect is already committed.

## Test plan
- Reset: hold rstn_i = 0 mid-RESP → ack/err drop asynchronously. After release, reading 0x0 returns 0 and 0x8 returns 0x0000_0001 (empty).
- SCRATCH byte lanes: write 0xDEADBEEF with sel = 4'hF, then 0x0000_5500 with sel = 4'h2 → read 0xDEAD55EF. Ack occurs exactly 1 cycle after the request, with no err.
- FIFO fill/overflow: push 1..8 with ready = 0 → STATUS shows full and level 8. Push 9 → acked, overflow = 1, level stays 8. Drain with ready = 1 → outputs 1..8 in order, then valid = 0.
- Simultaneous push+pop when full: ready = 1 on the same edge as a TXDATA push → level stays 8 and the new word appears after the existing seven.
- Error/decode: TXDATA write with sel = 4'h3 → err pulse, no push. Access at BASE_ADDR+0x10 → no ack and no err for 10 cycles.
- IRQ/flush: CTRL = 1 with the FIFO empty → irq_o = 1 one edge later. Push → irq_o = 0. Write CTRL = 3 → level 0 and irq_o = 1. W1C of 0x4 to STATUS clears overflow.

Source files
------------

// File: rtl/neorv32_wb_mailbox.sv
// Wishbone classic responder: scratch/status/control registers plus a transmit
// mailbox FIFO drained through a valid/ready stream, with an optional empty IRQ.
module neorv32_wb_mailbox #(
  parameter logic [31:0] BASE_ADDR  = 32'h9000_0000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [31:0] fifo_dout_o,
  output logic        fifo_valid_o,
  input  logic        fifo_ready_i,
  output logic        irq_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RESP = 1'b1;

  localparam logic [1:0] REG_SCRATCH = 2'd0;
  localparam logic [1:0] REG_TXDATA  = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  logic [0:0]       state_q, state_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [31:0]      dat_q, dat_d;
  logic [31:0]      scratch_q, scratch_d;
  logic             irq_en_q, irq_en_d;
  logic             ovf_q, ovf_d;
  logic             irq_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [31:0]      mem_q [FIFO_DEPTH];

  logic        req, accept, wr, rd;
  logic [1:0]  reg_sel;
  logic        empty, full;
  logic        push_req, bad_sel, flush, pop, push;
  logic [31:0] status_w, rdata;
  logic        unused_adr;

  assign unused_adr = ^wb_adr_i[1:0];

  assign req     = wb_cyc_i & wb_stb_i & (wb_adr_i[31:4] == BASE_ADDR[31:4]);
  assign accept  = (state_q == S_IDLE) & req;
  assign reg_sel = wb_adr_i[3:2];
  assign wr      = accept & wb_we_i;
  assign rd      = accept & ~wb_we_i;

  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_W'(FIFO_DEPTH));

  assign push_req = wr & (reg_sel == REG_TXDATA) & (wb_sel_i == 4'hF);
  assign bad_sel  = wr & (reg_sel == REG_TXDATA) & (wb_sel_i != 4'hF);
  assign flush    = wr & (reg_sel == REG_CTRL) & wb_sel_i[0] & wb_dat_i[1];
  assign pop      = ~empty & fifo_ready_i;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign push     = push_req & (~full | pop);

  always_comb begin
    status_w              = '0;
    status_w[0]           = empty;
    status_w[1]           = full;
    status_w[2]           = ovf_q;
    status_w[8 +: LVL_W]  = level_q;
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_SCRATCH: rdata = scratch_q;
      REG_TXDATA:  rdata = '0;
      REG_STATUS:  rdata = status_w;
      REG_CTRL:    rdata = {31'b0, irq_en_q};
      default:     rdata = '0;
    endcase
  end

  always_comb begin
    state_d = S_IDLE;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_RESP;
          err_d   = bad_sel;
          ack_d   = ~bad_sel;
          dat_d   = rd ? rdata : '0;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    scratch_d = scratch_q;
    irq_en_d  = irq_en_q;
    ovf_d     = ovf_q;
    if (wr && reg_sel == REG_SCRATCH) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wb_sel_i[i]) scratch_d[8*i +: 8] = wb_dat_i[8*i +: 8];
      end
    end
    if (wr && reg_sel == REG_CTRL && wb_sel_i[0]) irq_en_d = wb_dat_i[0];
    if (wr && reg_sel == REG_STATUS && wb_sel_i[0] && wb_dat_i[2]) begin
      ovf_d = 1'b0;
    end else if (push_req && full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= '0;
      scratch_q <= '0;
      irq_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      dat_q     <= dat_d;
      scratch_q <= scratch_d;
      irq_en_q  <= irq_en_d;
      ovf_q     <= ovf_d;
      irq_q     <= irq_en_q & empty;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
    end
  end

  // Storage needs no reset: the level counter alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wb_dat_i;
  end

  assign wb_ack_o     = ack_q;
  assign wb_err_o     = err_q;
  assign wb_dat_o     = dat_q;
  assign fifo_valid_o = ~empty;
  assign fifo_dout_o  = empty ? '0 : mem_q[rd_ptr_q];
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_neorv32_wb_mailbox.sv
// Scoreboard bench for neorv32_wb_mailbox: a queue-based reference model predicts
// bus responses, stream output and irq; monitors compare on the falling edge.
module tb_neorv32_wb_mailbox;

  localparam logic [31:0] BASE  = 32'h9000_0000;
  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic [31:0] rdat, fdout;
  logic        ack, err, fvalid, irq;
  logic        fready = 1'b0;

  neorv32_wb_mailbox #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .wb_cyc_i     (cyc),
    .wb_stb_i     (stb),
    .wb_we_i      (we),
    .wb_sel_i     (sel),
    .wb_adr_i     (adr),
    .wb_dat_i     (wdat),
    .wb_dat_o     (rdat),
    .wb_ack_o     (ack),
    .wb_err_o     (err),
    .fifo_dout_o  (fdout),
    .fifo_valid_o (fvalid),
    .fifo_ready_i (fready),
    .irq_o        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    bit          is_rd;
    logic [31:0] data;
  } resp_t;

  int          checks = 0;
  int          failures = 0;
  resp_t       sb[$];
  logic [31:0] mq[$];
  logic [31:0] m_scratch = '0;
  bit          m_irq_en = 1'b0, m_ovf = 1'b0, m_busy = 1'b0, exp_irq = 1'b0;
  bit          rand_rdy = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] status_word();
    logic [31:0] s;
    s    = 32'(mq.size()) << 8;
    s[0] = (mq.size() == 0);
    s[1] = (mq.size() == DEPTH);
    s[2] = m_ovf;
    return s;
  endfunction

  function automatic void model_reset();
    sb.delete();
    mq.delete();
    m_scratch = '0;
    m_irq_en  = 1'b0;
    m_ovf     = 1'b0;
    m_busy    = 1'b0;
    exp_irq   = 1'b0;
  endfunction

  // Reference model: evaluates each rising edge from the rules of the register map.
  initial begin
    forever begin
      @(posedge clk);
      if (!rstn) begin
        model_reset();
      end else begin : step
        bit          pop, flush, do_push, irq_next;
        logic [31:0] st;
        resp_t       r;
        int unsigned n0;
        n0       = mq.size();
        st       = status_word();
        irq_next = m_irq_en && (n0 == 0);
        pop      = (n0 > 0) && fready;
        flush    = 1'b0;
        do_push  = 1'b0;
        if (cyc && stb && adr[31:4] == BASE[31:4] && !m_busy) begin
          m_busy   = 1'b1;
          r.is_err = 1'b0;
          r.is_rd  = !we;
          r.data   = '0;
          case (adr[3:2])
            2'd0: if (we) begin
                    for (int b = 0; b < 4; b++)
                      if (sel[b]) m_scratch[8*b +: 8] = wdat[8*b +: 8];
                  end else r.data = m_scratch;
            2'd1: if (we) begin
                    if (sel != 4'hF) r.is_err = 1'b1;
                    else if (n0 < DEPTH || pop) do_push = 1'b1;
                    else m_ovf = 1'b1;
                  end
            2'd2: if (we) begin
                    if (sel[0] && wdat[2]) m_ovf = 1'b0;
                  end else r.data = st;
            default: if (we) begin
                    if (sel[0]) begin
                      m_irq_en = wdat[0];
                      flush    = wdat[1];
                    end
                  end else r.data = {31'b0, m_irq_en};
          endcase
          sb.push_back(r);
        end else begin
          m_busy = 1'b0;
        end
        if (flush) begin
          mq.delete();
        end else begin
          if (pop) void'(mq.pop_front());
          if (do_push) mq.push_back(wdat);
        end
        exp_irq = irq_next;
      end
    end
  end

  // Monitor: compares bus responses, stream output and irq against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        chk("irq", {31'b0, irq}, {31'b0, exp_irq});
        chk("fifo_valid", {31'b0, fvalid}, {31'b0, (mq.size() != 0)});
        if (mq.size() != 0) chk("fifo_dout", fdout, mq[0]);
        if (sb.size() != 0) begin
          resp_t r;
          r = sb.pop_front();
          chk("resp_ack_err", {30'b0, ack, err}, r.is_err ? 32'd1 : 32'd2);
          if (r.is_rd && !r.is_err) chk("rdata", rdat, r.data);
        end else begin
          chk("idle_bus", {30'b0, ack, err}, 32'd0);
          chk("idle_dat", rdat, 32'd0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    if (rand_rdy) fready = 1'($urandom_range(0, 1));
  endtask

  task automatic xfer(bit w, logic [31:0] a, logic [3:0] s, logic [31:0] d, bit rdy_pulse = 1'b0);
    tick();
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
    if (rdy_pulse) fready = 1'b1;
    @(posedge clk);
    tick();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (rdy_pulse) fready = 1'b0;
  endtask

  task automatic drain();
    fready = 1'b1;
    for (int i = 0; i < 40 && mq.size() != 0; i++) tick();
    tick();
    chk("valid_after_drain", {31'b0, fvalid}, 32'd0);
    fready = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_valid", {31'b0, fvalid}, 32'd0);
    chk("rst_ack", {31'b0, ack}, 32'd0);
    #1 rstn = 1'b1;

    // Reset while a response is being presented.
    tick();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; sel = 4'hF; wdat = 32'h1234_5678;
    @(posedge clk);
    #1 chk("ack_before_reset", {31'b0, ack}, 32'd1);
    rstn = 1'b0;
    model_reset();
    #1;
    chk("reset_ack", {31'b0, ack}, 32'd0);
    chk("reset_err", {31'b0, err}, 32'd0);
    chk("reset_dat", rdat, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    xfer(0, BASE + 32'h0, 4'hF, '0);
    xfer(0, BASE + 32'h8, 4'hF, '0);

    // Scratch byte lanes.
    xfer(1, BASE + 32'h0, 4'hF, 32'hDEAD_BEEF);
    xfer(1, BASE + 32'h0, 4'h2, 32'h0000_5500);
    xfer(0, BASE + 32'h0, 4'hF, '0);

    // Fill to full, overflow, drain.
    fready = 1'b0;
    for (int i = 1; i <= 8; i++) xfer(1, BASE + 32'h4, 4'hF, 32'(i));
    xfer(0, BASE + 32'h8, 4'hF, '0);
    xfer(1, BASE + 32'h4, 4'hF, 32'd9);
    xfer(0, BASE + 32'h8, 4'hF, '0);
    drain();

    // Push and pop on the same edge while full.
    for (int i = 0; i < 8; i++) xfer(1, BASE + 32'h4, 4'hF, $urandom);
    xfer(1, BASE + 32'h4, 4'hF, 32'hA5A5_0009, 1'b1);
    xfer(0, BASE + 32'h8, 4'hF, '0);
    drain();

    // Bad byte enables on TXDATA, then an undecoded offset.
    xfer(1, BASE + 32'h4, 4'h3, 32'h0BAD_0BAD);
    xfer(0, BASE + 32'h8, 4'hF, '0);
    tick();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h10; sel = 4'hF;
    n = 0;
    repeat (10) begin
      @(posedge clk);
      #1 if (ack || err) n++;
    end
    chk("out_of_range_resp", 32'(n), 32'd0);
    tick();
    cyc = 1'b0; stb = 1'b0;

    // Interrupt enable, push, flush, overflow clear.
    xfer(1, BASE + 32'hC, 4'hF, 32'd1);
    tick();
    chk("irq_on_empty", {31'b0, irq}, 32'd1);
    xfer(1, BASE + 32'h4, 4'hF, 32'h0000_0077);
    tick();
    chk("irq_off_after_push", {31'b0, irq}, 32'd0);
    xfer(1, BASE + 32'hC, 4'hF, 32'd3);
    tick();
    chk("irq_after_flush", {31'b0, irq}, 32'd1);
    xfer(0, BASE + 32'h8, 4'hF, '0);
    xfer(0, BASE + 32'hC, 4'hF, '0);
    xfer(1, BASE + 32'h8, 4'hF, 32'd4);
    xfer(0, BASE + 32'h8, 4'hF, '0);

    // Randomized traffic with a randomly stalling consumer.
    rand_rdy = 1'b1;
    repeat (400) begin
      logic [31:0] a, d;
      logic [3:0]  s;
      bit          w;
      a = BASE + 32'($urandom_range(0, 3)) * 4;
      if ($urandom_range(0, 9) == 0) a = BASE + 32'h20;
      w = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      d = $urandom;
      if (a[3:2] == 2'd3 && $urandom_range(0, 7) != 0) d[1] = 1'b0;
      xfer(w, a, s, d);
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_rdy = 1'b0;
    drain();
    repeat (3) tick();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
